risc_v_regfile_mp: RTL
======================

Name: risc_v_regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core: NUM_RD registered read ports, two write ports, x0 hard-wired to zero.
- After reset, an internal sequencer clears every register one entry per cycle and then raises init_done; the pipeline stalls until init_done is high.
- Read data is registered, with one-cycle latency, for use in a pipelined decode stage. Same-cycle write-to-read forwarding is optional.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, number of architectural registers; must be no greater than 2**ADDR_WIDTH.
- NUM_RD, 3, number of read ports (rs1, rs2, rs3).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- init_done  output  1  high once the clear sequence has finished.
- rd_en  input  NUM_RD  per-port read enable; bit i belongs to port i.
- rd_addr  input  NUM_RD*ADDR_WIDTH  flattened read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NUM_RD*DATA_WIDTH  flattened registered read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr0_en  input  1  write port 0 enable.
- wr0_addr  input  ADDR_WIDTH  write port 0 address.
- wr0_data  input  DATA_WIDTH  write port 0 data.
- wr1_en  input  1  write port 1 enable; has priority over port 0.
- wr1_addr  input  ADDR_WIDTH  write port 1 address.
- wr1_data  input  DATA_WIDTH  write port 1 data.

Behaviour:
- Reset (rst high at a clock edge):
  - FSM goes to CLEAR and clear index goes to 0.
  - init_done goes to 0 and all rd_data go to 0.
  - Reset asserted mid-CLEAR or during RUN restarts the sequence from index 0.
- FSM states:
  - CLEAR: one register is written with 0 per cycle at the clear index, which then increments. When the index equals NUM_REGS-1 that entry is cleared and the FSM moves to RUN. CLEAR therefore takes exactly NUM_REGS cycles after rst deasserts.
  - RUN: init_done is 1. The FSM stays in RUN until the next reset.
- init_done is registered. It rises on the same edge that clears entry NUM_REGS-1.
- During CLEAR:
  - wr0_en and wr1_en are ignored.
  - Any port with rd_en high loads 0 into its rd_data.
- Writes in RUN:
  - A write is committed on the edge on which it is enabled.
  - Any write addressed to 0 is dropped.
  - A write addressed to NUM_REGS or above is dropped.
  - Both ports enabled with the same address: wr1_data is stored and wr0 is discarded.
  - Both ports enabled with different addresses: both are stored.
- Reads in RUN:
  - rd_en[i] high at an edge: rd_data[i] is loaded with the register content, valid the following cycle (latency 1).
  - rd_en[i] low: rd_data[i] holds its previous value.
  - Address 0 always returns 0.
  - Address NUM_REGS or above returns 0.
- Read-during-write to the same address in the same cycle: behaviour is set by the optional feature below.
- Width rules: there is no arithmetic. Address comparisons are full ADDR_WIDTH compares.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled, non-zero, in-range write in the same cycle returns the write data.
  - If both write ports match, wr1_data is forwarded.
  - Gives write-first semantics, so the core needs no separate WB-to-ID forward.
- Undefined:
  - The read returns the pre-write register content (read-first).
  - The new value is visible from the next read onward.
- In both cases, address 0 always reads 0 and CLEAR always reads 0.

Test Plan:
- Clear sequence: hold rst high 2 cycles then release, with NUM_REGS=32 → init_done is 0 for exactly 32 cycles and 1 on the 32nd edge; reading x5 afterwards gives 0.
- Dual write: in RUN, wr0 writes x3=0x11111111 and wr1 writes x7=0x22222222 on the same edge; next cycle read x3 and x7 on ports 0 and 1 → 0x11111111 and 0x22222222 after one cycle.
- Write conflict: wr0 and wr1 both write x9, with 0xAAAA0000 and 0x0000BBBB respectively → a later read of x9 gives 0x0000BBBB.
- x0 protection: wr1 writes x0=0xDEADBEEF → a read of x0 on all three ports gives 0; rd_en low on port 2 → rd_data[2] holds its value.
- Bypass: x4=0x5, then in one cycle wr0 writes x4=0x6 while port 0 reads x4 → gives 0x6 with REGFILE_BYPASS_EN defined, 0x5 without it.
- Reset mid-operation: assert rst at clear index 10, and separately during RUN after writes → init_done drops and a full 32-cycle CLEAR is repeated; previously written registers read 0 afterwards, and writes during CLEAR are not retained.

Source files
------------

// File: rtl/risc_v_regfile_mp.sv
// risc_v_regfile_mp: multi-port RISC-V integer register file with post-reset clear sequencer
// Ports: clk, rst (sync, active-high); init_done high once every entry has been cleared;
//   rd_en/rd_addr/rd_data: NUM_RD registered read ports (latency 1), flattened per port;
//   wr0_*/wr1_*: two write ports, wr1 wins on an address conflict; x0 reads 0, writes to it drop.
// Option: define REGFILE_BYPASS_EN for write-first reads; default build is read-first.
module risc_v_regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_done,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         wr0_en,
  input  logic [ADDR_WIDTH-1:0]        wr0_addr,
  input  logic [DATA_WIDTH-1:0]        wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_WIDTH-1:0]        wr1_addr,
  input  logic [DATA_WIDTH-1:0]        wr1_data
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [ADDR_WIDTH:0]   NR   = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_idx;
  logic [DATA_WIDTH-1:0]   mem [NUM_REGS];
  logic                    w0, w1;
  assign w0 = state == RUN && wr0_en && wr0_addr != '0 && {1'b0, wr0_addr} < NR;
  assign w1 = state == RUN && wr1_en && wr1_addr != '0 && {1'b0, wr1_addr} < NR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      init_done <= 1'b0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end
  // wr1 is assigned last so it overrides wr0 on a shared address
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_idx] <= '0;
      if (w0) mem[wr0_addr] <= wr0_data;
      if (w1) mem[wr1_addr] <= wr1_data;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] q, nxt;
    logic                  ok;
    assign a  = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign ok = state == RUN && a != '0 && {1'b0, a} < NR;
`ifdef REGFILE_BYPASS_EN
    assign nxt = !ok ? '0 : (w1 && wr1_addr == a) ? wr1_data : (w0 && wr0_addr == a) ? wr0_data : mem[a];
`else
    assign nxt = ok ? mem[a] : '0;
`endif
    always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else if (rd_en[i]) q <= nxt;
    end
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = q;
  end
endmodule
